round_starter: RTL and testbench

Round-start controller for the Tug of War game. It sequences the LFSR random-bit generator to draw a random start delay, then counts that delay in slow-enable ticks and raises the GO lamp. It judges which player presses first and flags false starts. It sits between the generator, the debounced player buttons and the rope-position logic, which consumes its win/foul/tie pulses.

---
 rtl/tow_pkg.sv | 27 ++
 rtl/round_starter_if.sv | 28 ++
 rtl/round_starter_tick_counter.sv | 29 ++
 rtl/round_starter.sv | 116 +++++++++++
 tb/tb_round_starter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/tow_pkg.sv
// Shared Tug of War definitions: round-start FSM states, result pulse bundle and
// default timing constants shared with the rope-position logic.
package tow_pkg;

  localparam int DELAY_BITS_DEF = 4;
  localparam int MIN_DELAY_DEF  = 4;
  localparam int TIMEOUT_DEF    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    WAIT = 2'd2,
    GO   = 2'd3
  } state_t;

  typedef struct packed {
    logic win_l;
    logic win_r;
    logic foul_l;
    logic foul_r;
    logic tie;
    logic timeout;
  } result_t;

  localparam result_t RESULT_NONE = '0;

endpackage

// File: rtl/round_starter_if.sv
// Signal bundle between the round-start controller and its neighbours
// (clock divider tick, player buttons, random generator, rope logic).
interface round_starter_if;
  logic slowenable;
  logic start;
  logic btn_l;
  logic btn_r;
  logic rnd_bit;
  logic rnd_step;
  logic busy;
  logic go;
  logic win_l;
  logic win_r;
  logic foul_l;
  logic foul_r;
  logic tie;
  logic timeout;

  modport master (
    output slowenable, start, btn_l, btn_r, rnd_bit,
    input  rnd_step, busy, go, win_l, win_r, foul_l, foul_r, tie, timeout
  );

  modport slave (
    input  slowenable, start, btn_l, btn_r, rnd_bit,
    output rnd_step, busy, go, win_l, win_r, foul_l, foul_r, tie, timeout
  );
endinterface

// File: rtl/round_starter_tick_counter.sv
// Loadable down-counter of slow ticks; hits_zero flags the enabled tick that
// takes the count from 1 to 0, so the caller can act on that very edge.
module tick_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             hits_zero
);

  logic [WIDTH-1:0] count;

  // Load wins over a coincident tick, so the tick on the loading edge is not counted.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && (count != '0))
      count <= count - WIDTH'(1);
  end

  assign hits_zero = en && (count == WIDTH'(1));

endmodule

// File: rtl/round_starter.sv
// Round-start controller: draws a random delay from the LFSR, counts it in slow
// ticks, lights GO, then judges first press, false starts, ties and timeouts.
module round_starter
  import tow_pkg::*;
#(
  parameter int DELAY_BITS = DELAY_BITS_DEF,
  parameter int MIN_DELAY  = MIN_DELAY_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input logic             clk,
  input logic             rst,
  round_starter_if.slave  bus
);

  localparam int CW = DELAY_BITS + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(DELAY_BITS);

  state_t                state, state_nxt;
  result_t               res, res_nxt;
  logic [DELAY_BITS-1:0] delay;
  logic [DELAY_BITS-1:0] delay_shift;
  logic [BW-1:0]         bit_cnt;
  logic                  seed_last;
  logic                  dly_expire, tmo_expire;
  logic                  any_btn, both_btn;

  assign delay_shift = {delay[DELAY_BITS-2:0], bus.rnd_bit};
  assign seed_last   = (state == SEED) && (bit_cnt == BW'(DELAY_BITS - 1));
  assign any_btn     = bus.btn_l || bus.btn_r;
  assign both_btn    = bus.btn_l && bus.btn_r;

  tick_counter #(.WIDTH(CW)) u_delay_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (seed_last),
    .load_val  (CW'(MIN_DELAY) + CW'(delay_shift)),
    .en        (bus.slowenable && (state == WAIT)),
    .hits_zero (dly_expire)
  );

  // Reloaded on every entry to GO, i.e. on the edge that leaves WAIT for GO.
  tick_counter #(.WIDTH(TW)) u_timeout_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      ((state == WAIT) && (state_nxt == GO)),
    .load_val  (TW'(TIMEOUT)),
    .en        (bus.slowenable && (state == GO)),
    .hits_zero (tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      res     <= RESULT_NONE;
      delay   <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      res   <= res_nxt;
      if ((state == IDLE) && bus.start) begin
        delay   <= '0;
        bit_cnt <= '0;
      end else if (state == SEED) begin
        delay   <= delay_shift;
        bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

  // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
  always_comb begin
    state_nxt = state;
    res_nxt   = RESULT_NONE;
    unique case (state)
      IDLE: if (bus.start) state_nxt = SEED;
      SEED, WAIT: begin
        // A false start outranks the delay expiring on the same edge.
        if (any_btn) begin
          res_nxt.foul_l = bus.btn_l;
          res_nxt.foul_r = bus.btn_r;
          state_nxt      = IDLE;
        end else if (seed_last) begin
          state_nxt = WAIT;
        end else if ((state == WAIT) && dly_expire) begin
          state_nxt = GO;
        end
      end
      GO: begin
        if (both_btn) begin
          res_nxt.tie = 1'b1;
          state_nxt   = IDLE;
        end else if (any_btn) begin
          res_nxt.win_l = bus.btn_l;
          res_nxt.win_r = bus.btn_r;
          state_nxt     = IDLE;
        end else if (tmo_expire) begin
          res_nxt.timeout = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rnd_step = (state == SEED);
  assign bus.busy     = (state != IDLE);
  assign bus.go       = (state == GO);
  assign bus.win_l    = res.win_l;
  assign bus.win_r    = res.win_r;
  assign bus.foul_l   = res.foul_l;
  assign bus.foul_r   = res.foul_r;
  assign bus.tie      = res.tie;
  assign bus.timeout  = res.timeout;

endmodule

// File: tb/tb_round_starter.sv
// Self-checking bench for round_starter: table of rounds plus hand-written
// reset / ignored-start sequences; result pulses are matched against a scoreboard.
module tb_round_starter;
  import tow_pkg::*;

  localparam int DB = DELAY_BITS_DEF;
  localparam int MD = MIN_DELAY_DEF;
  localparam int TO = TIMEOUT_DEF;

  typedef enum int {ACT_PRESS, ACT_NONE, ACT_FOUL_SEED, ACT_FOUL_WAIT} act_t;
  typedef struct {
    logic [DB-1:0] bits;
    act_t          act;
    logic          bl;
    logic          br;
    int            press_tick;
    result_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  round_starter_if ifc ();

  round_starter #(.DELAY_BITS(DB), .MIN_DELAY(MD), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int            n_pass  = 0;
  int            n_total = 0;
  result_t       sb[$];
  vec_t          vecs[7];
  logic [DB-1:0] gen_bits = '0;
  int            gen_idx  = 0;
  logic          gen_step;
  result_t       got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic result_t mk(input logic wl, wr, fl, fr, t, tmo);
    return {wl, wr, fl, fr, t, tmo};
  endfunction

  function automatic logic [8:0] all_out();
    return {ifc.busy, ifc.go, ifc.rnd_step, ifc.win_l, ifc.win_r,
            ifc.foul_l, ifc.foul_r, ifc.tie, ifc.timeout};
  endfunction

  // Random generator stand-in: presents bits MSB first, advancing after each stepped edge.
  initial forever begin
    @(negedge clk);
    gen_step = ifc.rnd_step;
    @(posedge clk);
    #1;
    if (gen_step && gen_idx < DB - 1) begin
      gen_idx++;
      ifc.rnd_bit = gen_bits[DB-1-gen_idx];
    end
  end

  // Scoreboard: every result pulse must match the oldest expected entry.
  always @(negedge clk) begin
    got = {ifc.win_l, ifc.win_r, ifc.foul_l, ifc.foul_r, ifc.tie, ifc.timeout};
    if (got != RESULT_NONE) begin
      if (sb.size() == 0) check("unexpected_pulse", 32'(got), 32'(0));
      else check("result_pulse", 32'(got), 32'(sb.pop_front()));
    end
  end

  task automatic gen_load(input logic [DB-1:0] bits);
    gen_bits    = bits;
    gen_idx     = 0;
    ifc.rnd_bit = bits[DB-1];
  endtask

  task automatic tick(input logic se, bl, br, st);
    ifc.slowenable = se;
    ifc.btn_l      = bl;
    ifc.btn_r      = br;
    ifc.start      = st;
    @(posedge clk);
    #1;
    ifc.slowenable = 1'b0;
    ifc.btn_l      = 1'b0;
    ifc.btn_r      = 1'b0;
    ifc.start      = 1'b0;
  endtask

  task automatic slow_tick(input logic bl, br, st);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, bl, br, st);
  endtask

  task automatic rst_cycle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic finish_round(input string name);
    check({name, "_busy_end"}, 32'(ifc.busy), 32'(0));
    check({name, "_go_end"}, 32'(ifc.go), 32'(0));
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check({name, "_sb_empty"}, 32'(sb.size()), 32'(0));
  endtask

  task automatic run_round(input vec_t v, input string name);
    int steps;
    int d;
    int last;
    gen_load(v.bits);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check({name, "_busy_start"}, 32'(ifc.busy), 32'(1));
    if (v.act == ACT_FOUL_SEED) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      sb.push_back(v.exp);
      tick(1'b0, v.bl, v.br, 1'b0);
      finish_round(name);
      return;
    end
    // Seed phase; a tick on the final seed edge must not be counted.
    steps = 0;
    for (int i = 0; i < DB; i++) begin
      if (ifc.rnd_step) steps++;
      tick(i == DB - 1, 1'b0, 1'b0, 1'b0);
    end
    check({name, "_seed_steps"}, 32'(steps), 32'(DB));
    check({name, "_step_off"}, 32'(ifc.rnd_step), 32'(0));
    d = MD + int'(v.bits);
    for (int k = 1; k <= d; k++) begin
      if (v.act == ACT_FOUL_WAIT && k == v.press_tick) begin
        sb.push_back(v.exp);
        slow_tick(v.bl, v.br, 1'b0);
        finish_round(name);
        return;
      end
      slow_tick(1'b0, 1'b0, 1'b0);
      if (k == d - 1) check({name, "_go_early"}, 32'(ifc.go), 32'(0));
      if (k == d)     check({name, "_go_rise"}, 32'(ifc.go), 32'(1));
    end
    if (v.act == ACT_PRESS && v.press_tick == 0) begin
      sb.push_back(v.exp);
      tick(1'b0, v.bl, v.br, 1'b0);
    end else begin
      last = (v.act == ACT_NONE) ? TO : v.press_tick;
      for (int k = 1; k <= last; k++) begin
        if (k == last) begin
          sb.push_back(v.exp);
          slow_tick(v.act == ACT_PRESS ? v.bl : 1'b0, v.act == ACT_PRESS ? v.br : 1'b0, 1'b0);
        end else begin
          slow_tick(1'b0, 1'b0, 1'b0);
          if (k == last - 1) check({name, "_go_hold"}, 32'(ifc.go), 32'(1));
        end
      end
    end
    finish_round(name);
  endtask

  initial begin
    ifc.slowenable = 1'b0;
    ifc.start      = 1'b0;
    ifc.btn_l      = 1'b0;
    ifc.btn_r      = 1'b0;
    ifc.rnd_bit    = 1'b0;

    vecs[0] = '{4'hF, ACT_PRESS,     1'b0, 1'b1, 0,  mk(0, 1, 0, 0, 0, 0)};
    vecs[1] = '{4'h4, ACT_PRESS,     1'b1, 1'b0, 2,  mk(1, 0, 0, 0, 0, 0)};
    vecs[2] = '{4'hA, ACT_FOUL_WAIT, 1'b1, 1'b0, 3,  mk(0, 0, 1, 0, 0, 0)};
    vecs[3] = '{4'h9, ACT_FOUL_SEED, 1'b1, 1'b1, 0,  mk(0, 0, 1, 1, 0, 0)};
    vecs[4] = '{4'h0, ACT_PRESS,     1'b1, 1'b1, 0,  mk(0, 0, 0, 0, 1, 0)};
    vecs[5] = '{4'h3, ACT_NONE,      1'b0, 1'b0, 0,  mk(0, 0, 0, 0, 0, 1)};
    vecs[6] = '{4'h8, ACT_PRESS,     1'b0, 1'b1, TO, mk(0, 1, 0, 0, 0, 0)};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outputs", 32'(all_out()), 32'(0));
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    check("idle_ignores_buttons", 32'(all_out()), 32'(0));

    for (int i = 0; i < 7; i++) run_round(vecs[i], $sformatf("row%0d", i));

    // Reset during WAIT.
    gen_load(4'h5);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (DB) tick(1'b0, 1'b0, 1'b0, 1'b0);
    slow_tick(1'b0, 1'b0, 1'b0);
    slow_tick(1'b0, 1'b0, 1'b0);
    check("wait_busy_before_rst", 32'(ifc.busy), 32'(1));
    rst_cycle();
    check("rst_in_wait_outputs", 32'(all_out()), 32'(0));
    slow_tick(1'b0, 1'b0, 1'b0);
    check("rst_in_wait_stays_idle", 32'(all_out()), 32'(0));

    // Reset during GO.
    gen_load(4'h0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (DB) tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (MD) slow_tick(1'b0, 1'b0, 1'b0);
    check("go_before_rst", 32'(ifc.go), 32'(1));
    rst_cycle();
    check("rst_in_go_outputs", 32'(all_out()), 32'(0));

    // Starts while busy, including one on the expiring WAIT tick and one on the winning press.
    gen_load(4'h1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DB; i++) tick(1'b0, 1'b0, 1'b0, i == 1);
    check("seed_start_ignored", 32'(ifc.rnd_step), 32'(0));
    for (int k = 1; k < MD + 1; k++) slow_tick(1'b0, 1'b0, k == 2);
    check("restart_go_low", 32'(ifc.go), 32'(0));
    slow_tick(1'b0, 1'b0, 1'b1);
    check("expiry_start_go", 32'(ifc.go), 32'(1));
    check("expiry_start_no_seed", 32'(ifc.rnd_step), 32'(0));
    sb.push_back(mk(1, 0, 0, 0, 0, 0));
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    check("press_start_busy", 32'(ifc.busy), 32'(0));
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("press_start_ignored", 32'(all_out()), 32'(0));
    check("final_sb_empty", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
